// File: rtl/winocnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : winocnn_pkg
//  Brief    : Shared types, tile-edge defaults and helpers for the Winograd
//             convolution loop controller.
//  Revision : 1.0 - initial release
// ============================================================================
package winocnn_pkg;

    // Loop-sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DONE    = 2'd3
    } ctrl_state_t;

    // Output tile edges for the two tile modes (size_type=1 / size_type=0)
    localparam int unsigned TILE_A_DEFAULT = 4;
    localparam int unsigned TILE_B_DEFAULT = 6;

    // Ceiling division; a zero divisor yields zero rather than an X.
    function automatic logic [31:0] ceil_div(input logic [31:0] num,
                                             input logic [31:0] den);
        logic [31:0] q;
        if (den == 32'd0) begin
            q = 32'd0;
        end else begin
            q = num / den;
            if ((num % den) != 32'd0) begin
                q = q + 32'd1;
            end
        end
        return q;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tile_count_calc.sv
`default_nettype none
// ============================================================================
//  Module   : tile_count_calc
//  Brief    : Number of output tiles along one feature-map dimension:
//             max(1, ceil(dim/TILE)), saturated to the block-count width.
//  Revision : 1.0 - initial release
// ============================================================================
module tile_count_calc
    import winocnn_pkg::*;
#(
    parameter int unsigned DIM_W  = 9,
    parameter int unsigned BLK_W  = 8,
    parameter int unsigned TILE_A = TILE_A_DEFAULT,
    parameter int unsigned TILE_B = TILE_B_DEFAULT
) (
    input  logic [DIM_W-1:0] dim,
    input  logic             size_type,
    output logic [BLK_W-1:0] block
);

    localparam logic [31:0] BLK_MAX = (32'd1 << BLK_W) - 32'd1;

    logic [31:0] tile;
    logic [31:0] quot;

    // Pick the tile edge, divide rounding up, then clamp to [1, BLK_MAX]
    always_comb begin
        tile  = size_type ? 32'(TILE_A) : 32'(TILE_B);
        quot  = ceil_div(32'(dim), tile);
        if (quot == 32'd0) begin
            block = BLK_W'(1);
        end else if (quot > BLK_MAX) begin
            block = '1;
        end else begin
            block = quot[BLK_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_loop_controller.sv
`default_nettype none
// ============================================================================
//  Module   : conv_loop_controller
//  Brief    : Loop sequencer for one Winograd convolution layer. Walks
//             output-depth groups (inner) and input-depth slices (outer),
//             issuing one pass per (id, od-group) and waiting for each to end.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_loop_controller
    import winocnn_pkg::*;
#(
    parameter int unsigned OD_W     = 8,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned DIM_W    = 9,
    parameter int unsigned BLK_W    = 8,
    parameter int unsigned OD_LANES = 2,
    parameter int unsigned TILE_A   = TILE_A_DEFAULT,
    parameter int unsigned TILE_B   = TILE_B_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_wen_i,
    input  logic [ID_W-1:0]     cfg_total_id_i,
    input  logic [OD_W-1:0]     cfg_total_od_i,
    input  logic [DIM_W-1:0]    cfg_width_i,
    input  logic [DIM_W-1:0]    cfg_height_i,
    input  logic                cfg_size_type_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                loop_finished_i,
    output logic                data_prepare_o,
    output logic [ID_W-1:0]     data_id_o,
    output logic [ID_W-1:0]     weight_id_o,
    output logic [OD_W-1:0]     weight_od1_o,
    output logic [OD_LANES-1:0] weight_od_mask_o,
    output logic [BLK_W-1:0]    block_width_o,
    output logic [BLK_W-1:0]    block_height_o,
    output logic                size_type_o,
    output logic                busy_o,
    output logic [15:0]         pass_idx_o,
    output logic                conv_completed
);

    // Lane step widened by one bit so od1+OD_LANES never wraps near 2^OD_W
    localparam logic [OD_W:0] LANES_EXT = (OD_W+1)'(OD_LANES);

    ctrl_state_t      state, state_next;
    logic [OD_W-1:0]  od1, od1_next;
    logic [ID_W-1:0]  id, id_next;
    logic [15:0]      pass_idx, pass_next;

    logic [ID_W-1:0]  sh_total_id;
    logic [OD_W-1:0]  sh_total_od;
    logic [DIM_W-1:0] sh_width;
    logic [DIM_W-1:0] sh_height;
    logic             sh_size_type;

    logic [OD_W:0]    od_sum;
    logic [ID_W:0]    id_sum;
    logic             idle_like;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign od_sum    = {1'b0, od1} + LANES_EXT;
    assign id_sum    = {1'b0, id} + (ID_W+1)'(1);

    // Shadow configuration: writable only while no layer is in flight;
    // abort outranks the write so an aborting cycle leaves config untouched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_total_id  <= '0;
            sh_total_od  <= '0;
            sh_width     <= '0;
            sh_height    <= '0;
            sh_size_type <= 1'b0;
        end else if (cfg_wen_i && idle_like && !abort_i) begin
            sh_total_id  <= cfg_total_id_i;
            sh_total_od  <= cfg_total_od_i;
            sh_width     <= cfg_width_i;
            sh_height    <= cfg_height_i;
            sh_size_type <= cfg_size_type_i;
        end
    end

    // State and loop-counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            od1      <= '0;
            id       <= '0;
            pass_idx <= '0;
        end else begin
            state    <= state_next;
            od1      <= od1_next;
            id       <= id_next;
            pass_idx <= pass_next;
        end
    end

    // Next-state and loop-index update; abort wins over everything
    always_comb begin
        state_next = state;
        od1_next   = od1;
        id_next    = id;
        pass_next  = pass_idx;
        if (abort_i) begin
            state_next = ST_IDLE;
            od1_next   = '0;
            id_next    = '0;
            pass_next  = '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        od1_next  = '0;
                        id_next   = '0;
                        pass_next = '0;
                        // An empty layer has no passes to issue
                        if (sh_total_od == '0 || sh_total_id == '0) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (loop_finished_i) begin
                        state_next = ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    pass_next = pass_idx + 16'd1;
                    if (od_sum >= {1'b0, sh_total_od}) begin
                        if (id_sum >= {1'b0, sh_total_id}) begin
                            state_next = ST_DONE;
                        end else begin
                            od1_next   = '0;
                            id_next    = id_sum[ID_W-1:0];
                            state_next = ST_ISSUE;
                        end
                    end else begin
                        od1_next   = od_sum[OD_W-1:0];
                        state_next = ST_ISSUE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Lane-valid mask: lane k carries a real channel only if od1+k < total_od
    genvar k;
    generate
        for (k = 0; k < OD_LANES; k = k + 1) begin : g_mask
            assign weight_od_mask_o[k] =
                (({1'b0, od1} + (OD_W+1)'(k)) < {1'b0, sh_total_od});
        end
    endgenerate

    tile_count_calc #(
        .DIM_W  (DIM_W),
        .BLK_W  (BLK_W),
        .TILE_A (TILE_A),
        .TILE_B (TILE_B)
    ) u_tiles_w (
        .dim       (sh_width),
        .size_type (sh_size_type),
        .block     (block_width_o)
    );

    tile_count_calc #(
        .DIM_W  (DIM_W),
        .BLK_W  (BLK_W),
        .TILE_A (TILE_A),
        .TILE_B (TILE_B)
    ) u_tiles_h (
        .dim       (sh_height),
        .size_type (sh_size_type),
        .block     (block_height_o)
    );

    assign data_prepare_o = (state == ST_ISSUE);
    assign busy_o         = (state == ST_ISSUE) || (state == ST_ADVANCE);
    assign conv_completed = (state == ST_DONE);
    assign data_id_o      = id;
    assign weight_id_o    = id;
    assign weight_od1_o   = od1;
    assign pass_idx_o     = pass_idx;
    assign size_type_o    = sh_size_type;

endmodule

`default_nettype wire

// File: tb/tb_conv_loop_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_loop_controller
//  Brief    : Self-checking bench for conv_loop_controller: block-count
//             vector table plus scoreboarded pass sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_loop_controller;

    localparam int OD_W     = 8;
    localparam int ID_W     = 4;
    localparam int DIM_W    = 9;
    localparam int BLK_W    = 8;
    localparam int OD_LANES = 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                cfg_wen_i;
    logic [ID_W-1:0]     cfg_total_id_i;
    logic [OD_W-1:0]     cfg_total_od_i;
    logic [DIM_W-1:0]    cfg_width_i;
    logic [DIM_W-1:0]    cfg_height_i;
    logic                cfg_size_type_i;
    logic                start_i;
    logic                abort_i;
    logic                loop_finished_i;
    logic                data_prepare_o;
    logic [ID_W-1:0]     data_id_o;
    logic [ID_W-1:0]     weight_id_o;
    logic [OD_W-1:0]     weight_od1_o;
    logic [OD_LANES-1:0] weight_od_mask_o;
    logic [BLK_W-1:0]    block_width_o;
    logic [BLK_W-1:0]    block_height_o;
    logic                size_type_o;
    logic                busy_o;
    logic [15:0]         pass_idx_o;
    logic                conv_completed;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [ID_W-1:0]     id;
        logic [OD_W-1:0]     od1;
        logic [OD_LANES-1:0] mask;
        logic [15:0]         idx;
    } pass_t;

    pass_t sb[$];

    typedef struct {
        logic [DIM_W-1:0] w;
        logic [DIM_W-1:0] h;
        logic             st;
        logic [BLK_W-1:0] bw;
        logic [BLK_W-1:0] bh;
    } blk_vec_t;

    blk_vec_t vt[6];

    conv_loop_controller #(
        .OD_W(OD_W), .ID_W(ID_W), .DIM_W(DIM_W), .BLK_W(BLK_W),
        .OD_LANES(OD_LANES), .TILE_A(4), .TILE_B(6)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cfg_wen_i        (cfg_wen_i),
        .cfg_total_id_i   (cfg_total_id_i),
        .cfg_total_od_i   (cfg_total_od_i),
        .cfg_width_i      (cfg_width_i),
        .cfg_height_i     (cfg_height_i),
        .cfg_size_type_i  (cfg_size_type_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .loop_finished_i  (loop_finished_i),
        .data_prepare_o   (data_prepare_o),
        .data_id_o        (data_id_o),
        .weight_id_o      (weight_id_o),
        .weight_od1_o     (weight_od1_o),
        .weight_od_mask_o (weight_od_mask_o),
        .block_width_o    (block_width_o),
        .block_height_o   (block_height_o),
        .size_type_o      (size_type_o),
        .busy_o           (busy_o),
        .pass_idx_o       (pass_idx_o),
        .conv_completed   (conv_completed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Build the expected pass list of a layer from first principles
    task automatic push_layer(input int tod, input int tid);
        int idx = 0;
        for (int i = 0; i < tid; i++) begin
            for (int o = 0; o < tod; o += OD_LANES) begin
                pass_t p;
                p.id  = ID_W'(i);
                p.od1 = OD_W'(o);
                for (int k = 0; k < OD_LANES; k++) begin
                    p.mask[k] = ((o + k) < tod);
                end
                p.idx = 16'(idx);
                idx++;
                sb.push_back(p);
            end
        end
    endtask

    task automatic set_cfg(input int tid, input int tod, input int w,
                           input int h, input logic st);
        @(negedge clk);
        cfg_total_id_i  = ID_W'(tid);
        cfg_total_od_i  = OD_W'(tod);
        cfg_width_i     = DIM_W'(w);
        cfg_height_i    = DIM_W'(h);
        cfg_size_type_i = st;
        cfg_wen_i       = 1'b1;
        @(negedge clk);
        cfg_wen_i       = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Answer n passes: compare each against the scoreboard head, finish it
    // three cycles after it was seen, then check the ADVANCE gap cycle
    task automatic serve_passes(input int n);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            pass_t e;
            do begin
                @(negedge clk);
                g++;
            end while (!data_prepare_o && g < 50);
            if (!data_prepare_o) begin
                check("pass_timeout", 32'(data_prepare_o), 32'd1);
                return;
            end
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
                return;
            end
            e = sb.pop_front();
            check("pass_id",      32'(data_id_o),        32'(e.id));
            check("pass_wid",     32'(weight_id_o),      32'(e.id));
            check("pass_od1",     32'(weight_od1_o),     32'(e.od1));
            check("pass_mask",    32'(weight_od_mask_o), 32'(e.mask));
            check("pass_idx",     32'(pass_idx_o),       32'(e.idx));
            check("pass_busy",    32'(busy_o),           32'd1);
            repeat (2) @(negedge clk);
            loop_finished_i = 1'b1;
            @(negedge clk);
            loop_finished_i = 1'b0;
            check("adv_prepare",  32'(data_prepare_o),   32'd0);
            check("adv_busy",     32'(busy_o),           32'd1);
        end
    endtask

    task automatic finish_layer(input int total);
        @(negedge clk);
        check("done_completed", 32'(conv_completed), 32'd1);
        check("done_pass_idx",  32'(pass_idx_o),     32'(total));
        check("done_busy",      32'(busy_o),         32'd0);
        check("done_sb_empty",  32'(sb.size()),      32'd0);
    endtask

    initial begin
        reset_n         = 1'b0;
        cfg_wen_i       = 1'b0;
        cfg_total_id_i  = '0;
        cfg_total_od_i  = '0;
        cfg_width_i     = '0;
        cfg_height_i    = '0;
        cfg_size_type_i = 1'b0;
        start_i         = 1'b0;
        abort_i         = 1'b0;
        loop_finished_i = 1'b0;

        vt[0] = '{w: 9'd13,  h: 9'd24,  st: 1'b0, bw: 8'd3,   bh: 8'd4};
        vt[1] = '{w: 9'd13,  h: 9'd24,  st: 1'b1, bw: 8'd4,   bh: 8'd6};
        vt[2] = '{w: 9'd0,   h: 9'd0,   st: 1'b0, bw: 8'd1,   bh: 8'd1};
        vt[3] = '{w: 9'd511, h: 9'd511, st: 1'b1, bw: 8'd128, bh: 8'd128};
        vt[4] = '{w: 9'd511, h: 9'd6,   st: 1'b0, bw: 8'd86,  bh: 8'd1};
        vt[5] = '{w: 9'd7,   h: 9'd1,   st: 1'b1, bw: 8'd2,   bh: 8'd1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_prepare",   32'(data_prepare_o),   32'd0);
        check("rst_busy",      32'(busy_o),           32'd0);
        check("rst_completed", 32'(conv_completed),   32'd0);
        check("rst_pass_idx",  32'(pass_idx_o),       32'd0);
        check("rst_od1",       32'(weight_od1_o),     32'd0);
        check("rst_id",        32'(data_id_o),        32'd0);
        check("rst_mask",      32'(weight_od_mask_o), 32'd0);
        check("rst_size_type", 32'(size_type_o),      32'd0);
        reset_n = 1'b1;

        // Block-count vector table
        for (int i = 0; i < 6; i++) begin
            set_cfg(1, 1, int'(vt[i].w), int'(vt[i].h), vt[i].st);
            check("blk_width",  32'(block_width_o),  32'(vt[i].bw));
            check("blk_height", 32'(block_height_o), 32'(vt[i].bh));
            check("blk_size",   32'(size_type_o),    32'(vt[i].st));
        end

        // Stray loop_finished in IDLE is ignored
        @(negedge clk);
        loop_finished_i = 1'b1;
        @(negedge clk);
        loop_finished_i = 1'b0;
        check("idle_lf_ignored", 32'(busy_o), 32'd0);

        // Four-pass layer: od=4, id=2
        set_cfg(2, 4, 13, 24, 1'b0);
        push_layer(4, 2);
        pulse_start();
        serve_passes(4);
        finish_layer(4);

        // Ragged final group: od=5, id=1, plus restart straight from DONE
        set_cfg(1, 5, 13, 24, 1'b0);
        push_layer(5, 1);
        pulse_start();
        check("restart_cleared", 32'(conv_completed), 32'd0);
        serve_passes(3);
        finish_layer(3);

        // Empty layer: total_id=0 goes to DONE with no pass issued
        set_cfg(0, 4, 13, 24, 1'b0);
        pulse_start();
        check("empty_done",    32'(conv_completed), 32'd1);
        check("empty_prepare", 32'(data_prepare_o), 32'd0);
        begin
            int seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (data_prepare_o) seen++;
            end
            check("empty_no_pass", 32'(seen), 32'd0);
        end

        // Abort during ISSUE of pass 2, then a clean full layer
        set_cfg(2, 4, 13, 24, 1'b0);
        push_layer(4, 2);
        pulse_start();
        serve_passes(1);
        @(negedge clk);
        check("pre_abort_issue", 32'(data_prepare_o), 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_prepare",   32'(data_prepare_o), 32'd0);
        check("abort_busy",      32'(busy_o),         32'd0);
        check("abort_od1",       32'(weight_od1_o),   32'd0);
        check("abort_id",        32'(data_id_o),      32'd0);
        check("abort_pass_idx",  32'(pass_idx_o),     32'd0);
        check("abort_completed", 32'(conv_completed), 32'd0);
        check("abort_cfg_kept",  32'(block_width_o),  32'd3);
        sb.delete();
        push_layer(4, 2);
        pulse_start();
        serve_passes(4);
        finish_layer(4);

        // Config write while busy is ignored; same write in DONE takes effect
        push_layer(4, 2);
        pulse_start();
        set_cfg(1, 5, 40, 40, 1'b1);
        check("busy_cfg_ignored", 32'(size_type_o), 32'd0);
        serve_passes(4);
        finish_layer(4);
        set_cfg(1, 5, 40, 40, 1'b1);
        check("done_cfg_size",  32'(size_type_o),   32'd1);
        check("done_cfg_block", 32'(block_width_o), 32'd10);
        push_layer(5, 1);
        pulse_start();
        serve_passes(3);
        finish_layer(3);

        // Asynchronous reset mid-pass
        sb.delete();
        push_layer(5, 1);
        pulse_start();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("areset_prepare", 32'(data_prepare_o), 32'd0);
        check("areset_busy",    32'(busy_o),         32'd0);
        check("areset_size",    32'(size_type_o),    32'd0);
        check("areset_mask",    32'(weight_od_mask_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
